// File: rtl/bus85_slave_pkg.sv
// Shared types and constants for the 8085-style AD-bus responder.
package bus85_slave_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StAct,
    StDone,
    StSkip
  } state_e;

  // RST 7 opcode, returned during interrupt acknowledge by default.
  localparam logic [7:0] Rst7Opcode = 8'hFF;

  localparam int unsigned CntWidth = 4;

  function automatic logic strobe_low(logic rd_n, logic wr_n, logic inta_n);
    return !(rd_n && wr_n && inta_n);
  endfunction

endpackage

// File: rtl/bus85_slave_if.sv
// Multiplexed 8085-style address/data bus between a core and bus85_slave.
interface bus85_slave_if #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 16
);
  logic [ADDRSIZE-DATASIZE-1:0] addr;
  logic                         iom_;
  logic                         ale;
  logic                         rd_;
  logic                         wr_;
  logic                         inta_;
  logic                         ready;
  logic [DATASIZE-1:0]          ad_m;
  logic                         ad_m_oe;
  logic [DATASIZE-1:0]          ad_s;
  logic                         ad_s_oe;
  wire  [DATASIZE-1:0]          addrdata;

  // Pad model; the slave wins so a read-during-write error shows slave data.
  assign addrdata = ad_s_oe ? ad_s : (ad_m_oe ? ad_m : 'z);

  modport slave (
    input  addr, iom_, ale, rd_, wr_, inta_, addrdata,
    output ready, ad_s, ad_s_oe
  );

  modport master (
    input  ready, addrdata, ad_s_oe,
    output addr, iom_, ale, rd_, wr_, inta_, ad_m, ad_m_oe
  );
endinterface

// File: rtl/bus85_slave_ram.sv
// Synchronous-write, asynchronous-read byte RAM behind bus85_slave.
module bus85_slave_ram #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned MEMABITS = 10
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [MEMABITS-1:0] addr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  output logic [DATASIZE-1:0] rdata_o
);
  localparam int unsigned Depth = 2 ** MEMABITS;

  logic [DATASIZE-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus85_slave.sv
// AD-bus responder: address latch, decode, wait-state FSM, RAM, one I/O port
// and an interrupt-vector responder for an 8085-style core.
module bus85_slave
  import bus85_slave_pkg::*;
#(
  parameter int unsigned         DATASIZE = 8,
  parameter int unsigned         ADDRSIZE = 16,
  parameter int unsigned         MEMABITS = 10,
  parameter logic [DATASIZE-1:0] IOADDR   = 8'h80,
  parameter int unsigned         WAITS    = 0,
  parameter logic [DATASIZE-1:0] INTVEC   = Rst7Opcode
) (
  input  logic                clk,
  input  logic                rst_,
  bus85_slave_if.slave        bus,
  input  logic [DATASIZE-1:0] port_in,
  output logic [DATASIZE-1:0] port_out,
  output logic                port_wr
);
  localparam logic [CntWidth-1:0] WaitLoad = (WAITS > 0) ? CntWidth'(WAITS - 1) : '0;

  state_e                state_q;
  logic [ADDRSIZE-1:0]   lat_q;
  logic                  lat_iom_q;
  logic                  cyc_inta_q;
  logic                  rd_seen_q;
  logic                  wr_seen_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DATASIZE-1:0]   wbuf_q;
  logic [DATASIZE-1:0]   port_out_q;
  logic                  port_wr_q;

  logic                  strobe;
  logic                  mem_hit;
  logic                  io_hit;
  logic                  addr_sel;
  logic                  sel;
  logic                  commit;
  logic                  ram_we;
  logic [DATASIZE-1:0]   ram_rdata;
  logic [DATASIZE-1:0]   ad_data;

  assign strobe   = strobe_low(bus.rd_, bus.wr_, bus.inta_);
  assign mem_hit  = !lat_iom_q && (lat_q[ADDRSIZE-1:MEMABITS] == '0);
  assign io_hit   = lat_iom_q && (lat_q[DATASIZE-1:0] == IOADDR);
  // Before the strobe is registered, the live inta_ decides selection.
  assign addr_sel = !bus.inta_ || mem_hit || io_hit;
  assign sel      = cyc_inta_q || mem_hit || io_hit;
  // A cycle that ever saw a read strobe is never committed as a write.
  assign commit   = wr_seen_q && !rd_seen_q;
  assign ram_we   = (state_q == StDone) && !bus.ale && commit && !lat_iom_q && !cyc_inta_q;

  bus85_slave_ram #(
    .DATASIZE(DATASIZE),
    .MEMABITS(MEMABITS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (lat_q[MEMABITS-1:0]),
    .wdata_i(wbuf_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= StIdle;
      lat_q      <= '0;
      lat_iom_q  <= 1'b0;
      cyc_inta_q <= 1'b0;
      rd_seen_q  <= 1'b0;
      wr_seen_q  <= 1'b0;
      cnt_q      <= '0;
      wbuf_q     <= '0;
      port_out_q <= '0;
      port_wr_q  <= 1'b0;
    end else begin
      port_wr_q <= 1'b0;
      if (bus.ale) begin
        // A new address phase aborts whatever cycle was in flight.
        lat_q      <= {bus.addr, bus.addrdata};
        lat_iom_q  <= bus.iom_;
        cyc_inta_q <= 1'b0;
        rd_seen_q  <= 1'b0;
        wr_seen_q  <= 1'b0;
        state_q    <= StAddr;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StAddr: begin
            if (strobe) begin
              cyc_inta_q <= !bus.inta_;
              if (!addr_sel) begin
                state_q <= StSkip;
              end else if (WAITS > 0) begin
                cnt_q   <= WaitLoad;
                state_q <= StWait;
              end else begin
                state_q <= StAct;
              end
            end
          end
          StWait: begin
            if (cnt_q == '0) begin
              state_q <= StAct;
            end else begin
              cnt_q <= cnt_q - CntWidth'(1);
            end
          end
          StAct: begin
            if (!bus.rd_ || !bus.inta_) begin
              rd_seen_q <= 1'b1;
            end
            if (!bus.wr_) begin
              wbuf_q    <= bus.addrdata;
              wr_seen_q <= 1'b1;
            end
            if (!strobe) begin
              state_q <= StDone;
            end
          end
          StDone: begin
            if (commit && lat_iom_q && !cyc_inta_q) begin
              port_out_q <= wbuf_q;
              port_wr_q  <= 1'b1;
            end
            state_q <= StIdle;
          end
          StSkip: begin
            if (!strobe) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    ad_data = ram_rdata;
    if (!bus.inta_) begin
      ad_data = INTVEC;
    end else if (lat_iom_q) begin
      ad_data = port_in;
    end
  end

  assign bus.ready   = (state_q != StWait);
  assign bus.ad_s    = ad_data;
  assign bus.ad_s_oe = (state_q == StAct) && (!bus.rd_ || !bus.inta_) && sel;
  assign port_out    = port_out_q;
  assign port_wr     = port_wr_q;

endmodule
